// File: rtl/lut_neuron_layer_rt_if.sv
// Bundled configuration port and valid/ready streams for the LUT neuron layer.
interface lut_neuron_layer_rt_if #(
  parameter int unsigned NUM_NEURONS = 4,
  parameter int unsigned ADDR_BITS   = 6,
  parameter int unsigned OUT_BITS    = 1
);
  localparam int unsigned NB = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  logic                            cfg_we;
  logic [NB-1:0]                   cfg_neuron;
  logic [ADDR_BITS-1:0]            cfg_addr;
  logic [OUT_BITS-1:0]             cfg_data;
  logic                            cfg_err;
  logic                            in_valid;
  logic                            in_ready;
  logic [NUM_NEURONS*ADDR_BITS-1:0] in_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [NUM_NEURONS*OUT_BITS-1:0] out_data;
  logic                            init_busy;

  modport master (
    output cfg_we, cfg_neuron, cfg_addr, cfg_data, in_valid, in_data, out_ready,
    input  cfg_err, in_ready, out_valid, out_data, init_busy
  );

  modport slave (
    input  cfg_we, cfg_neuron, cfg_addr, cfg_data, in_valid, in_data, out_ready,
    output cfg_err, in_ready, out_valid, out_data, init_busy
  );
endinterface

// File: rtl/lut_neuron_layer_rt.sv
// Runtime-loadable layer of LUT neurons: two-stage pipeline (address, lookup)
// with tables cleared on reset and rewritten through the configuration port.
//
// state | meaning
// INIT  | sweeping every table entry to zero, inputs blocked, cfg ignored
// RUN   | streaming lookups, cfg writes accepted
module lut_neuron_layer_rt #(
  parameter int unsigned NUM_NEURONS = 4,
  parameter int unsigned ADDR_BITS   = 6,
  parameter int unsigned OUT_BITS    = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  lut_neuron_layer_rt_if.slave bus
);
  localparam int unsigned NB    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam logic [NB:0] NEURON_LIMIT = (NB+1)'(NUM_NEURONS);

  typedef enum logic {INIT, RUN} state_t;

  state_t                           state;
  logic [ADDR_BITS-1:0]             init_cnt;
  logic                             a_valid;
  logic                             b_valid;
  logic [NUM_NEURONS*ADDR_BITS-1:0] a_data;
  logic [NUM_NEURONS*OUT_BITS-1:0]  b_data;
  logic [NUM_NEURONS*OUT_BITS-1:0]  lookup;
  logic                             init_busy_q;
  logic                             cfg_err_q;
  logic [OUT_BITS-1:0]              tbl [NUM_NEURONS][DEPTH];

  logic advance;
  logic accept;
  logic cfg_in_range;
  logic cfg_ok;

  assign advance      = !b_valid || bus.out_ready;
  assign bus.in_ready = (state == RUN) && (!a_valid || advance);
  assign accept       = bus.in_valid && bus.in_ready;
  assign cfg_in_range = ({1'b0, bus.cfg_neuron} < NEURON_LIMIT);
  assign cfg_ok       = (state == RUN) && bus.cfg_we && cfg_in_range;

  assign bus.out_valid = b_valid;
  assign bus.out_data  = b_data;
  assign bus.init_busy = init_busy_q;
  assign bus.cfg_err   = cfg_err_q;

  // Asynchronous read: a write landing on the same edge is not yet visible.
  always_comb begin
    lookup = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      lookup[n*OUT_BITS +: OUT_BITS] = tbl[n][a_data[n*ADDR_BITS +: ADDR_BITS]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == INIT) begin
        for (int n = 0; n < NUM_NEURONS; n++) begin
          tbl[n][init_cnt] <= '0;
        end
      end else if (cfg_ok) begin
        tbl[bus.cfg_neuron][bus.cfg_addr] <= bus.cfg_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= INIT;
      init_cnt    <= '0;
      init_busy_q <= 1'b1;
      cfg_err_q   <= 1'b0;
      a_valid     <= 1'b0;
      b_valid     <= 1'b0;
      a_data      <= '0;
      b_data      <= '0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + ADDR_BITS'(1);
          if (init_cnt == '1) begin
            state       <= RUN;
            init_busy_q <= 1'b0;
          end
        end
        RUN: begin
          if (bus.cfg_we && !cfg_in_range) cfg_err_q <= 1'b1;
        end
        default: state <= INIT;
      endcase

      if (accept) begin
        a_data  <= bus.in_data;
        a_valid <= 1'b1;
      end else if (advance) begin
        a_valid <= 1'b0;
      end

      if (advance) begin
        b_valid <= a_valid;
        b_data  <= lookup;
      end
    end
  end
endmodule

// File: tb/tb_lut_neuron_layer_rt.sv
// Randomized bench for lut_neuron_layer_rt against a table-array reference model.
module tb_lut_neuron_layer_rt;
  localparam int NN = 3;
  localparam int AB = 6;
  localparam int OB = 1;
  localparam int NB = 2;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lut_neuron_layer_rt_if #(.NUM_NEURONS(NN), .ADDR_BITS(AB), .OUT_BITS(OB)) bus ();
  lut_neuron_layer_rt #(.NUM_NEURONS(NN), .ADDR_BITS(AB), .OUT_BITS(OB)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [OB-1:0]    model_tbl [NN][DEPTH];
  logic [NN*AB-1:0] words[$];
  logic [NN*AB-1:0] acc_q[$];
  int               acc_cyc[$];
  logic [NN*OB-1:0] out_q[$];
  int               out_cyc[$];

  function automatic logic [NN*OB-1:0] model_out(input logic [NN*AB-1:0] w);
    logic [NN*OB-1:0] r;
    r = '0;
    for (int n = 0; n < NN; n++) r[n*OB +: OB] = model_tbl[n][w[n*AB +: AB]];
    return r;
  endfunction

  task automatic clear_model();
    for (int n = 0; n < NN; n++)
      for (int a = 0; a < DEPTH; a++) model_tbl[n][a] = '0;
  endtask

  task automatic clear_queues();
    words.delete(); acc_q.delete(); acc_cyc.delete(); out_q.delete(); out_cyc.delete();
  endtask

  task automatic idle_inputs();
    bus.cfg_we = 1'b0; bus.cfg_neuron = '0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
  endtask

  // Called at posedge+1 with inputs already set; records handshakes at the negedge.
  task automatic cycle();
    @(negedge clk);
    if (rst_n && bus.in_valid && bus.in_ready) begin
      acc_q.push_back(bus.in_data); acc_cyc.push_back(cyc);
    end
    if (rst_n && bus.out_valid && bus.out_ready) begin
      out_q.push_back(bus.out_data); out_cyc.push_back(cyc);
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic cfg_write(input int n, input int a, input logic [OB-1:0] d);
    bus.cfg_we = 1'b1; bus.cfg_neuron = NB'(n); bus.cfg_addr = AB'(a); bus.cfg_data = d;
    if (n < NN) model_tbl[n][a] = d;
    cycle();
    bus.cfg_we = 1'b0;
  endtask

  task automatic stream_run(input int n, input int mode);
    int guard = 0;
    while ((acc_q.size() < n || out_q.size() < n) && guard < 4000) begin
      bus.in_valid = (acc_q.size() < n);
      if (acc_q.size() < n) bus.in_data = words[acc_q.size()];
      bus.out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      cycle();
      guard++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    clear_model();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
    checks++; if (bus.init_busy !== 1'b1) begin errors++; $display("FAIL reset_init_busy: got %b expected 1", bus.init_busy); end
    checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b expected 0", bus.cfg_err); end
    rst_n = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      if (i == 10) begin bus.cfg_we = 1'b1; bus.cfg_neuron = 2'd0; bus.cfg_addr = 6'd7; bus.cfg_data = 1'b1; end
      if (i == 11) bus.cfg_neuron = 2'd3;
      if (i == 12) bus.cfg_we = 1'b0;
      @(posedge clk); #1; cyc++;
      checks++;
      if (bus.in_ready !== 1'(i == DEPTH)) begin
        errors++; $display("FAIL init_in_ready cycle %0d: got %b expected %b", i, bus.in_ready, (i == DEPTH));
      end
      checks++;
      if (bus.init_busy !== 1'(i != DEPTH)) begin
        errors++; $display("FAIL init_busy cycle %0d: got %b expected %b", i, bus.init_busy, (i != DEPTH));
      end
    end
    checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL init_cfg_err: got %b expected 0", bus.cfg_err); end
  endtask

  task automatic test_init_lookup();
    clear_queues();
    words.push_back({AB'($urandom), AB'($urandom), 6'd7});
    for (int i = 1; i < 16; i++) words.push_back(NN*AB'($urandom));
    stream_run(16, 0);
    checks++; if (out_q.size() != 16) begin errors++; $display("FAIL init_lookup_count: got %0d expected 16", out_q.size()); end
    for (int i = 0; i < out_q.size() && i < 16; i++) begin
      checks++;
      if (out_q[i] !== model_out(words[i])) begin
        errors++; $display("FAIL init_lookup word %0d: got %h expected %h", i, out_q[i], model_out(words[i]));
      end
    end
  endtask

  task automatic test_load_and_stream();
    for (int a = 0; a < DEPTH; a++) begin
      logic [AB-1:0] av;
      av = AB'(a);
      cfg_write(0, a, ^av);
      cfg_write(1, a, OB'(a >= 32));
      cfg_write(2, a, OB'($urandom));
    end
    clear_queues();
    for (int i = 0; i < DEPTH; i++) words.push_back({AB'($urandom), AB'(i), AB'(i)});
    stream_run(DEPTH, 0);
    checks++; if (out_q.size() != DEPTH) begin errors++; $display("FAIL stream_count: got %0d expected %0d", out_q.size(), DEPTH); end
    for (int i = 0; i < out_q.size() && i < DEPTH; i++) begin
      checks++;
      if (out_q[i] !== model_out(words[i])) begin
        errors++; $display("FAIL stream_data word %0d: got %h expected %h", i, out_q[i], model_out(words[i]));
      end
      checks++;
      if (out_cyc[i] - acc_cyc[i] != 2) begin
        errors++; $display("FAIL stream_latency word %0d: got %0d expected 2", i, out_cyc[i] - acc_cyc[i]);
      end
      checks++;
      if (acc_cyc[i] - acc_cyc[0] != i) begin
        errors++; $display("FAIL stream_throughput word %0d: got %0d expected %0d", i, acc_cyc[i] - acc_cyc[0], i);
      end
    end
    if (out_q.size() > 33) begin
      checks++;
      if (out_q[33][1:0] !== 2'b10) begin errors++; $display("FAIL stream_addr21: got %b expected 10", out_q[33][1:0]); end
    end
  endtask

  task automatic test_backpressure();
    clear_queues();
    for (int i = 0; i < 20; i++) words.push_back(NN*AB'($urandom));
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_data = words[acc_q.size()];
      cycle();
    end
    checks++; if (acc_q.size() != 2) begin errors++; $display("FAIL bp_accepted: got %0d expected 2", acc_q.size()); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", bus.in_ready); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== model_out(words[0])) begin
        errors++; $display("FAIL bp_hold %0d: got v=%b d=%h expected v=1 d=%h", i, bus.out_valid, bus.out_data, model_out(words[0]));
      end
      cycle();
    end
    stream_run(20, 1);
    checks++; if (out_q.size() != 20) begin errors++; $display("FAIL bp_count: got %0d expected 20", out_q.size()); end
    for (int i = 0; i < out_q.size() && i < 20; i++) begin
      checks++;
      if (out_q[i] !== model_out(words[i])) begin
        errors++; $display("FAIL bp_data word %0d: got %h expected %h", i, out_q[i], model_out(words[i]));
      end
    end
  endtask

  task automatic test_collision();
    clear_queues();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = {AB'($urandom), AB'($urandom), 6'd5};
    cycle();
    bus.cfg_we = 1'b1; bus.cfg_neuron = 2'd0; bus.cfg_addr = 6'd5; bus.cfg_data = 1'b1;
    bus.in_data = {AB'($urandom), AB'($urandom), 6'd5};
    cycle();
    model_tbl[0][5] = 1'b1;
    bus.cfg_we = 1'b0; bus.in_valid = 1'b0;
    repeat (4) cycle();
    checks++; if (out_q.size() != 2) begin errors++; $display("FAIL coll_count: got %0d expected 2", out_q.size()); end
    if (out_q.size() == 2) begin
      checks++; if (out_q[0][0] !== 1'b0) begin errors++; $display("FAIL coll_old: got %b expected 0", out_q[0][0]); end
      checks++; if (out_q[1][0] !== 1'b1) begin errors++; $display("FAIL coll_new: got %b expected 1", out_q[1][0]); end
    end
  endtask

  task automatic test_bad_config();
    cfg_write(3, int'($urandom_range(0, DEPTH-1)), 1'b1);
    checks++; if (bus.cfg_err !== 1'b1) begin errors++; $display("FAIL badcfg_set: got %b expected 1", bus.cfg_err); end
    cfg_write(3, int'($urandom_range(0, DEPTH-1)), 1'b0);
    cfg_write(2, 0, OB'($urandom));
    repeat (3) cycle();
    checks++; if (bus.cfg_err !== 1'b1) begin errors++; $display("FAIL badcfg_sticky: got %b expected 1", bus.cfg_err); end
    clear_queues();
    for (int i = 0; i < DEPTH; i++) words.push_back({AB'(i), AB'(i), AB'(i)});
    stream_run(DEPTH, 1);
    checks++; if (out_q.size() != DEPTH) begin errors++; $display("FAIL badcfg_count: got %0d expected %0d", out_q.size(), DEPTH); end
    for (int i = 0; i < out_q.size() && i < DEPTH; i++) begin
      checks++;
      if (out_q[i] !== model_out(words[i])) begin
        errors++; $display("FAIL badcfg_table addr %0d: got %h expected %h", i, out_q[i], model_out(words[i]));
      end
    end
  endtask

  task automatic test_midstream_reset();
    clear_queues();
    for (int i = 0; i < 4; i++) words.push_back(NN*AB'($urandom));
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = words[acc_q.size()];
      cycle();
    end
    checks++; if (acc_q.size() != 2) begin errors++; $display("FAIL mrst_fill: got %0d expected 2", acc_q.size()); end
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk); #1; cyc++;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mrst_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL mrst_out_data: got %h expected 0", bus.out_data); end
    checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL mrst_cfg_err: got %b expected 0", bus.cfg_err); end
    checks++; if (bus.init_busy !== 1'b1) begin errors++; $display("FAIL mrst_init_busy: got %b expected 1", bus.init_busy); end
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    clear_model();
    for (int i = 1; i <= DEPTH; i++) begin
      @(posedge clk); #1; cyc++;
      checks++;
      if (bus.in_ready !== 1'(i == DEPTH)) begin
        errors++; $display("FAIL mrst_in_ready cycle %0d: got %b expected %b", i, bus.in_ready, (i == DEPTH));
      end
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mrst_stale cycle %0d: got out_valid=%b expected 0", i, bus.out_valid); end
    end
    clear_queues();
    for (int i = 0; i < DEPTH; i++) words.push_back({AB'(i), AB'(i), AB'(i)});
    stream_run(DEPTH, 0);
    checks++; if (out_q.size() != DEPTH) begin errors++; $display("FAIL mrst_count: got %0d expected %0d", out_q.size(), DEPTH); end
    for (int i = 0; i < out_q.size() && i < DEPTH; i++) begin
      checks++;
      if (out_q[i] !== model_out(words[i])) begin
        errors++; $display("FAIL mrst_cleared addr %0d: got %h expected %h", i, out_q[i], model_out(words[i]));
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_init_lookup();
    test_load_and_stream();
    test_backpressure();
    test_collision();
    test_bad_config();
    test_midstream_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
